// File: rtl/ahb_splitter_1m4s_if.sv
// ============================================================================
//  ahb_splitter_1m4s_if : one AHB-Lite point-to-point link (address, control,
//  write data forward; ready, read data, response back).
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface ahb_splitter_1m4s_if #(
    parameter int SZ = 64
);
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [SZ-1:0] HWDATA;
    logic          HSEL;
    logic          HREADY;     // HREADYIN towards the slave side
    logic          HREADYOUT;  // ready returned by the slave side
    logic [SZ-1:0] HRDATA;
    logic          HRESP;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HSEL, HREADY,
        input  HREADYOUT, HRDATA, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HSEL, HREADY,
        output HREADYOUT, HRDATA, HRESP
    );
endinterface

`default_nettype wire

// File: rtl/ahb_splitter_1m4s.sv
// ============================================================================
//  ahb_splitter_1m4s : AHB-Lite 1-master / 4-slave address decoder, response
//  multiplexor and built-in ERROR default slave.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module ahb_splitter_1m4s #(
    parameter int         SZ      = 64,
    parameter logic [3:0] S0_PAGE = 4'h0,
    parameter logic [3:0] S1_PAGE = 4'h2,
    parameter logic [3:0] S2_PAGE = 4'h4,
    parameter logic [3:0] S3_PAGE = 4'h8
) (
    input  wire logic          HCLK,
    input  wire logic          HRESETn,
    ahb_splitter_1m4s_if.slave  mst,   // HREADYOUT here is HREADY to the master
    ahb_splitter_1m4s_if.master s0,
    ahb_splitter_1m4s_if.master s1,
    ahb_splitter_1m4s_if.master s2,
    ahb_splitter_1m4s_if.master s3
);

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

    logic [3:0]    page;
    logic [3:0]    hit;
    logic [4:0]    sel;     // {DEF, S3, S2, S1, S0}
    logic [4:0]    dsel;    // all-zero = no data phase in flight
    logic          hready;
    logic          hresp;
    logic [SZ-1:0] hrdata;
    logic          active;
    ds_state_t     ds_state;
    ds_state_t     ds_next;
    logic          ds_ready;
    logic          ds_resp;

    // Decode: lowest index wins on overlapping pages
    assign page = mst.HADDR[31:28];
    assign hit  = {page == S3_PAGE, page == S2_PAGE, page == S1_PAGE, page == S0_PAGE};

    always_comb begin
        sel = 5'b0;
        if      (hit[0]) sel[0] = 1'b1;
        else if (hit[1]) sel[1] = 1'b1;
        else if (hit[2]) sel[2] = 1'b1;
        else if (hit[3]) sel[3] = 1'b1;
        else             sel[4] = 1'b1;
    end

    assign active = mst.HTRANS[1];

    // Broadcast of the master address/control/data to every slave
    assign s0.HADDR = mst.HADDR;  assign s1.HADDR = mst.HADDR;
    assign s2.HADDR = mst.HADDR;  assign s3.HADDR = mst.HADDR;
    assign s0.HTRANS = mst.HTRANS; assign s1.HTRANS = mst.HTRANS;
    assign s2.HTRANS = mst.HTRANS; assign s3.HTRANS = mst.HTRANS;
    assign s0.HWRITE = mst.HWRITE; assign s1.HWRITE = mst.HWRITE;
    assign s2.HWRITE = mst.HWRITE; assign s3.HWRITE = mst.HWRITE;
    assign s0.HSIZE = mst.HSIZE;  assign s1.HSIZE = mst.HSIZE;
    assign s2.HSIZE = mst.HSIZE;  assign s3.HSIZE = mst.HSIZE;
    assign s0.HWDATA = mst.HWDATA; assign s1.HWDATA = mst.HWDATA;
    assign s2.HWDATA = mst.HWDATA; assign s3.HWDATA = mst.HWDATA;
    assign s0.HREADY = hready;    assign s1.HREADY = hready;
    assign s2.HREADY = hready;    assign s3.HREADY = hready;
    assign s0.HSEL = sel[0];      assign s1.HSEL = sel[1];
    assign s2.HSEL = sel[2];      assign s3.HSEL = sel[3];

    // Data-phase owner advances only when the current data phase completes
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dsel <= 5'b0;
        end else if (hready) begin
            dsel <= active ? sel : 5'b0;
        end
    end

    always_comb begin
        hready = 1'b1;
        hresp  = 1'b0;
        hrdata = '0;
        if (dsel[0]) begin
            hready = s0.HREADYOUT; hresp = s0.HRESP; hrdata = s0.HRDATA;
        end else if (dsel[1]) begin
            hready = s1.HREADYOUT; hresp = s1.HRESP; hrdata = s1.HRDATA;
        end else if (dsel[2]) begin
            hready = s2.HREADYOUT; hresp = s2.HRESP; hrdata = s2.HRDATA;
        end else if (dsel[3]) begin
            hready = s3.HREADYOUT; hresp = s3.HRESP; hrdata = s3.HRDATA;
        end else if (dsel[4]) begin
            hready = ds_ready;     hresp = ds_resp;
        end
    end

    assign mst.HREADYOUT = hready;
    assign mst.HRESP     = hresp;
    assign mst.HRDATA    = hrdata;

    // Default slave: two-cycle ERROR for active transfers to unmapped pages
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ds_state <= DS_IDLE;
        end else begin
            ds_state <= ds_next;
        end
    end

    always_comb begin
        ds_next  = ds_state;
        ds_ready = 1'b1;
        ds_resp  = 1'b0;
        case (ds_state)
            DS_IDLE: begin
                if (hready && active && sel[4]) ds_next = DS_ERR1;
            end
            DS_ERR1: begin
                ds_ready = 1'b0;
                ds_resp  = 1'b1;
                ds_next  = DS_ERR2;
            end
            DS_ERR2: begin
                ds_resp = 1'b1;
                ds_next = (hready && active && sel[4]) ? DS_ERR1 : DS_IDLE;
            end
            default: ds_next = DS_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_ahb_splitter_1m4s.sv
// ============================================================================
//  tb_ahb_splitter_1m4s : directed self-checking bench for ahb_splitter_1m4s.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ahb_splitter_1m4s;

    localparam int SZ = 64;
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;

    logic HCLK;
    logic HRESETn;
    int   checks;
    int   errors;

    ahb_splitter_1m4s_if #(.SZ(SZ)) mst ();
    ahb_splitter_1m4s_if #(.SZ(SZ)) s0 ();
    ahb_splitter_1m4s_if #(.SZ(SZ)) s1 ();
    ahb_splitter_1m4s_if #(.SZ(SZ)) s2 ();
    ahb_splitter_1m4s_if #(.SZ(SZ)) s3 ();

    ahb_splitter_1m4s #(.SZ(SZ)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .mst     (mst),
        .s0      (s0),
        .s1      (s1),
        .s2      (s2),
        .s3      (s3)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #100000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then leave 1 time unit for new stimulus
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic [1:0] t, input logic w);
        mst.HADDR  = a;
        mst.HTRANS = t;
        mst.HWRITE = w;
        mst.HSIZE  = 3'd3;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        HRESETn = 1'b0;
        mst.HSEL = 1'b1; mst.HREADY = 1'b1;
        mst.HWDATA = '0;
        addr_phase(32'h4000_0000, IDLE, 1'b0);
        s0.HREADYOUT = 1'b1; s0.HRESP = 1'b0; s0.HRDATA = '0;
        s1.HREADYOUT = 1'b1; s1.HRESP = 1'b0; s1.HRDATA = 64'hDEAD_BEEF_0123_4567;
        s2.HREADYOUT = 1'b1; s2.HRESP = 1'b0; s2.HRDATA = '0;
        s3.HREADYOUT = 1'b1; s3.HRESP = 1'b0; s3.HRDATA = '0;

        // Reset state; decode keeps following HADDR
        tick();
        #1;
        check("rst_hready", 64'(mst.HREADYOUT), 64'd1);
        check("rst_hresp",  64'(mst.HRESP),     64'd0);
        check("rst_hrdata", mst.HRDATA,         64'd0);
        check("rst_hsel2",  64'({s3.HSEL, s2.HSEL, s1.HSEL, s0.HSEL}), 64'b0100);
        HRESETn = 1'b1;
        tick();

        // Zero-wait read from S1
        addr_phase(32'h2000_0010, NONSEQ, 1'b0);
        #1;
        check("rd_hsel1", 64'({s3.HSEL, s2.HSEL, s1.HSEL, s0.HSEL}), 64'b0010);
        check("rd_haddr_s", 64'(s1.HADDR), 64'h2000_0010);
        tick();
        addr_phase(32'h0000_0000, IDLE, 1'b0);
        #1;
        check("rd_hrdata", mst.HRDATA,         64'hDEAD_BEEF_0123_4567);
        check("rd_hresp",  64'(mst.HRESP),     64'd0);
        check("rd_hready", 64'(mst.HREADYOUT), 64'd1);
        tick();
        check("rd_after_none", mst.HRDATA, 64'd0);

        // S0 write with two wait states overlapping an S3 address phase
        addr_phase(32'h0000_0000, NONSEQ, 1'b1);
        tick();
        addr_phase(32'h8000_0004, NONSEQ, 1'b1);
        mst.HWDATA = 64'h0000_0000_AAAA_0000;
        s0.HREADYOUT = 1'b0;
        #1;
        check("wr_s0_wait1",  64'(mst.HREADYOUT), 64'd0);
        check("wr_s3_hsel",   64'(s3.HSEL),       64'd1);
        check("wr_s3_hrdyin", 64'(s3.HREADY),     64'd0);
        check("wr_s0_hwdata", s0.HWDATA,          64'h0000_0000_AAAA_0000);
        tick();
        check("wr_s0_wait2",  64'(mst.HREADYOUT), 64'd0);
        s0.HREADYOUT = 1'b1;
        #1;
        check("wr_s0_done",   64'(mst.HREADYOUT), 64'd1);
        tick();
        addr_phase(32'h0000_0000, IDLE, 1'b0);
        mst.HWDATA = 64'h3333_3333_0000_0004;
        s3.HREADYOUT = 1'b0;
        #1;
        check("wr_own_s3",    64'(mst.HREADYOUT), 64'd0);
        check("wr_s3_hwdata", s3.HWDATA,          64'h3333_3333_0000_0004);
        s3.HREADYOUT = 1'b1;
        tick();

        // Single unmapped NONSEQ
        addr_phase(32'hF000_0000, NONSEQ, 1'b0);
        #1;
        check("um_hsel_none", 64'({s3.HSEL, s2.HSEL, s1.HSEL, s0.HSEL}), 64'b0000);
        tick();
        addr_phase(32'h0000_0000, IDLE, 1'b0);
        #1;
        check("um_err1", 64'({mst.HREADYOUT, mst.HRESP}), 64'b01);
        check("um_hrdata", mst.HRDATA, 64'd0);
        tick();
        check("um_err2", 64'({mst.HREADYOUT, mst.HRESP}), 64'b11);
        tick();
        check("um_idle", 64'({mst.HREADYOUT, mst.HRESP}), 64'b10);

        // Back-to-back unmapped: second issued while the first sits in DS_ERR2
        addr_phase(32'hF000_0000, NONSEQ, 1'b0);
        tick();
        addr_phase(32'hE000_0008, NONSEQ, 1'b0);
        #1;
        check("b2b_err1a", 64'({mst.HREADYOUT, mst.HRESP}), 64'b01);
        tick();
        check("b2b_err2a", 64'({mst.HREADYOUT, mst.HRESP}), 64'b11);
        tick();
        addr_phase(32'h0000_0000, IDLE, 1'b0);
        #1;
        check("b2b_err1b", 64'({mst.HREADYOUT, mst.HRESP}), 64'b01);
        tick();
        check("b2b_err2b", 64'({mst.HREADYOUT, mst.HRESP}), 64'b11);
        tick();
        check("b2b_idle",  64'({mst.HREADYOUT, mst.HRESP}), 64'b10);

        // IDLE transfer to unmapped space gets a zero-wait OKAY
        addr_phase(32'hC000_0000, IDLE, 1'b0);
        tick();
        check("idle_um_1", 64'({mst.HREADYOUT, mst.HRESP}), 64'b10);
        tick();
        check("idle_um_2", 64'({mst.HREADYOUT, mst.HRESP}), 64'b10);

        // Asynchronous reset in the middle of an S2 wait state
        addr_phase(32'h4000_0000, NONSEQ, 1'b0);
        tick();
        addr_phase(32'h0000_0000, IDLE, 1'b0);
        s2.HREADYOUT = 1'b0;
        s2.HRESP     = 1'b1;
        s2.HRDATA    = 64'h2222_2222_2222_2222;
        #1;
        check("s2_wait",   64'(mst.HREADYOUT), 64'd0);
        check("s2_hrdata", mst.HRDATA,         64'h2222_2222_2222_2222);
        HRESETn = 1'b0;
        #1;
        check("arst_hready", 64'(mst.HREADYOUT), 64'd1);
        check("arst_hresp",  64'(mst.HRESP),     64'd0);
        check("arst_hrdata", mst.HRDATA,         64'd0);
        tick();
        HRESETn = 1'b1;
        s2.HREADYOUT = 1'b1;
        s2.HRESP     = 1'b0;
        s0.HRDATA    = 64'h1111_2222_3333_4444;
        tick();

        // Normal S0 read after reset release
        addr_phase(32'h0000_0100, NONSEQ, 1'b0);
        #1;
        check("post_hsel0", 64'({s3.HSEL, s2.HSEL, s1.HSEL, s0.HSEL}), 64'b0001);
        tick();
        addr_phase(32'h0000_0000, IDLE, 1'b0);
        #1;
        check("post_hrdata", mst.HRDATA, 64'h1111_2222_3333_4444);
        check("post_resp",   64'({mst.HREADYOUT, mst.HRESP}), 64'b10);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
